mul_nbit_serial: RTL and testbench



---
 rtl/mul_nbit_serial.sv | 142 ++++++++++++++
 tb/tb_mul_nbit_serial.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_nbit_serial.sv
// Shift-add serial multiplier: retires one multiplier bit per clock, holds the product in a result register.
// Optional signed mode is built in when MUL_SIGNED_EN is defined (adds the signed_mode port and the neg flag).
module mul_nbit_serial #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operA,
  input  logic [WIDTH-1:0]     operB,
`ifdef MUL_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Handshake: start is level-sampled only in IDLE; the accepting edge latches
  // the operands and raises busy. busy stays high through RUN and DONE, done
  // pulses for one cycle with the new result, and the block then returns to IDLE.
  state_e                 state_q, state_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     result_q, result_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [2*WIDTH-1:0]     sum;
`ifdef MUL_SIGNED_EN
  logic                   neg_q, neg_d;
  logic                   a_neg, b_neg;
`endif

  always_comb begin
`ifdef MUL_SIGNED_EN
    // Magnitude of the most negative operand is 2^(WIDTH-1), which still fits unsigned.
    a_neg = signed_mode & operA[WIDTH-1];
    b_neg = signed_mode & operB[WIDTH-1];
    a_mag = a_neg ? (~operA + 1'b1) : operA;
    b_mag = b_neg ? (~operB + 1'b1) : operB;
    neg_d = neg_q;
`else
    a_mag = operA;
    b_mag = operB;
`endif
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
`ifdef MUL_SIGNED_EN
          neg_d    = a_neg ^ b_neg;
`endif
        end
      end
      ST_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
          result_d = neg_q ? (~sum + 1'b1) : sum;
`else
          result_d = sum;
`endif
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_nbit_serial.sv
// Directed bench for mul_nbit_serial: a WIDTH=4 instance for the main checks and a WIDTH=8 instance for the wide extreme.
// Signed vectors run only when MUL_SIGNED_EN is defined.
module tb_mul_nbit_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op_a, op_b;
  logic        sm;
  logic [7:0]  result;
  logic        busy, done;
  logic [1:0]  state_dbg;

  logic        start8;
  logic [7:0]  op_a8, op_b8;
  logic [15:0] result8;
  logic        busy8, done8;
  logic [1:0]  state_dbg8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_nbit_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .operA(op_a), .operB(op_b),
`ifdef MUL_SIGNED_EN
    .signed_mode(sm),
`endif
    .result(result), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  mul_nbit_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .operA(op_a8), .operB(op_b8),
`ifdef MUL_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .result(result8), .busy(busy8), .done(done8), .state_dbg(state_dbg8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Wait for done on the WIDTH=4 instance; returns edges waited (bounded).
  task automatic wait_done4(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] exp, input string tag);
    int lat;
    op_a = a; op_b = b; sm = s; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = ~a; op_b = ~b; sm = ~s;
    check({tag, "_busy"}, busy, 1);
    wait_done4(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_res"}, result, exp);
    tick();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sm = 1'b0;
    start8 = 1'b0; op_a8 = '0; op_b8 = '0;
    tick(); tick();
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // 4*2 with start held, then 3*5 back-to-back; operands scrambled during RUN.
    op_a = 4'd4; op_b = 4'd2; start = 1'b1;
    tick();
    check("t1_busy", busy, 1);
    check("t1_done0", done, 0);
    wait_done4(lat);
    check("t1_lat", lat, 4);
    check("t1_res", result, 8);
    op_a = 4'd3; op_b = 4'd5;
    tick();
    check("t1_gap_busy", busy, 0);
    check("t1_gap_done", done, 0);
    check("t1_hold", result, 8);
    tick();
    check("t2_busy", busy, 1);
    check("t2_hold", result, 8);
    op_a = 4'd9; op_b = 4'd9;
    wait_done4(lat);
    check("t2_lat", lat, 4);
    check("t2_res", result, 15);
    start = 1'b0;
    tick();
    check("t2_done_low", done, 0);

    do_op(4'd0, 4'd9, 1'b0, 8'd0, "zero");
    do_op(4'd15, 4'd15, 1'b0, 8'd225, "max");

    // Reset during the second RUN cycle aborts with no done pulse.
    op_a = 4'd5; op_b = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", result, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_idle", busy, 0);
    do_op(4'd7, 4'd6, 1'b0, 8'd42, "after_abort");

    // start pulsed in RUN and in DONE is ignored.
    op_a = 4'd2; op_b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op_a = 4'd15; op_b = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_run_busy", busy, 1);
    pulses = 0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("ign_res", result, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_done_busy", busy, 0);
    check("ign_done_low", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("ign_no_extra", pulses, 0);
    check("ign_hold", result, 6);

`ifdef MUL_SIGNED_EN
    do_op(4'h8, 4'd7, 1'b1, 8'hC8, "s_m8x7");
    do_op(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
    do_op(4'd3, 4'hB, 1'b1, 8'hF1, "s_3xm5");
    do_op(4'hF, 4'hF, 1'b0, 8'd225, "s_off_ff");
`endif

    // WIDTH=8 extreme.
    op_a8 = 8'd255; op_b8 = 8'd255; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    op_a8 = 8'd0; op_b8 = 8'd0;
    check("w8_busy", busy8, 1);
    lat = 0;
    while (!done8 && lat < 30) begin
      tick();
      lat++;
    end
    check("w8_lat", lat, 8);
    check("w8_res", result8, 65025);
    tick();
    check("w8_done_low", done8, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
